// File: rtl/i2s_pkg.sv
// Shared defaults and state/channel types for the I2S record-path capture block.
package i2s_pkg;

  localparam int unsigned SAMPLE_BITS_DEF = 16;
  localparam int unsigned BUF_LEN_DEF     = 256;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DRAIN = 2'd3
  } rx_state_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input, with a rising-edge pulse
// derived from the synchronized level.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~level_d;

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S record-path receiver: captures left/right words in the clk domain, presents
// complete frames with a valid/ready handshake and writes their average to a ring buffer.
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int unsigned BUF_LEN     = BUF_LEN_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          audio_I2S_bclk,
  input  logic                          audio_I2S_reclrc,
  input  logic                          audio_I2S_recdat,
  input  logic                          enable,
  output logic signed [SAMPLE_BITS-1:0] sample_left,
  output logic signed [SAMPLE_BITS-1:0] sample_right,
  output logic                          valid,
  input  logic                          ready,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(BUF_LEN)-1:0]    buf_addr,
  output logic [SAMPLE_BITS-1:0]        buf_data,
  output logic                          buf_we
);

  localparam int unsigned AW = $clog2(BUF_LEN);
  localparam int unsigned CW = $clog2(SAMPLE_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);

  logic bclk_s, bclk_rise, lrc_s, lrc_rise, dat_s, dat_rise;
  logic unused_sig;

  rx_state_e              state, state_next;
  chan_e                  chan, chan_next;
  logic                   lrc_prev;
  logic [CW-1:0]          cnt, cnt_next, bit_pos;
  logic [SAMPLE_BITS-1:0] shreg, shreg_next, word_c, left_hold, left_next;
  logic                   lrc_chg, lrc_fall, last_bit, word_done, frame_done;
  logic [SAMPLE_BITS:0]   sum_c;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .rstn(rstn), .din(audio_I2S_bclk), .level(bclk_s), .rise_c(bclk_rise)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrc (
    .clk(clk), .rstn(rstn), .din(audio_I2S_reclrc), .level(lrc_s), .rise_c(lrc_rise)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .rstn(rstn), .din(audio_I2S_recdat), .level(dat_s), .rise_c(dat_rise)
  );

  assign unused_sig = ^{bclk_s, lrc_rise, dat_rise, sum_c[0]};

  // Word-select is only meaningful at bclk rising edges.
  assign lrc_chg  = bclk_rise && (lrc_s != lrc_prev);
  assign lrc_fall = lrc_chg && !lrc_s;
  assign last_bit = (cnt == LAST_BIT);
  assign bit_pos  = LAST_BIT - cnt;

  // Sign-extended sum; dropping bit 0 is the arithmetic shift right by one.
  assign sum_c = {left_hold[SAMPLE_BITS-1], left_hold} + {word_c[SAMPLE_BITS-1], word_c};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable) state_next = ST_ALIGN;
      ST_ALIGN: if (lrc_fall) state_next = ST_SHIFT;
      ST_SHIFT: if (bclk_rise && !lrc_chg && last_bit) state_next = ST_DRAIN;
      ST_DRAIN: if (lrc_chg) state_next = ST_SHIFT;
      default:  state_next = ST_IDLE;
    endcase
    if (!enable) state_next = ST_IDLE;
  end

  // Datapath actions; the bit seen on a word-select change is the previous LSB and is dropped.
  always_comb begin
    shreg_next = shreg;
    cnt_next   = cnt;
    chan_next  = chan;
    left_next  = left_hold;
    word_c     = shreg;
    word_done  = 1'b0;
    frame_done = 1'b0;
    if (enable && bclk_rise) begin
      case (state)
        ST_ALIGN: begin
          if (lrc_fall) begin
            shreg_next = '0;
            cnt_next   = '0;
            chan_next  = CH_LEFT;
          end
        end
        ST_SHIFT: begin
          if (lrc_chg) begin
            word_done  = 1'b1;
            shreg_next = '0;
            cnt_next   = '0;
            chan_next  = chan_e'(lrc_s);
          end else begin
            word_c[bit_pos] = dat_s;
            if (last_bit) begin
              word_done  = 1'b1;
              shreg_next = '0;
            end else begin
              shreg_next = word_c;
              cnt_next   = cnt + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (lrc_chg) begin
            shreg_next = '0;
            cnt_next   = '0;
            chan_next  = chan_e'(lrc_s);
          end
        end
        default: ;
      endcase
      if (word_done) begin
        if (chan == CH_LEFT) left_next  = word_c;
        else                 frame_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lrc_prev     <= 1'b0;
      chan         <= CH_LEFT;
      cnt          <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      buf_addr     <= '0;
      buf_data     <= '0;
      buf_we       <= 1'b0;
    end else begin
      if (bclk_rise) lrc_prev <= lrc_s;
      chan      <= chan_next;
      cnt       <= cnt_next;
      shreg     <= shreg_next;
      left_hold <= left_next;
      buf_we    <= frame_done;
      if (buf_we) buf_addr <= buf_addr + AW'(1);
      if (frame_done) begin
        sample_left  <= left_hold;
        sample_right <= word_c;
        buf_data     <= sum_c[SAMPLE_BITS:1];
      end
      if (frame_done)          valid <= 1'b1;
      else if (valid && ready) valid <= 1'b0;
      // A frame landing on an unconsumed one wins over a same-cycle clear.
      if (frame_done && valid && !ready) overflow <= 1'b1;
      else if (clear_overflow)           overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Scoreboard bench for i2s_rx_capture: stimulus queues expected frames, a monitor
// checks each buf_we cycle against the queue head.
module tb_i2s_rx_capture;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] avg;
    logic [7:0]  addr;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0, rstn = 1'b0, bclk = 1'b0, lrc = 1'b0, dat = 1'b0;
  logic enable = 1'b0, ready = 1'b1, clear_overflow = 1'b0;
  logic signed [15:0] sample_left, sample_right;
  logic        valid, overflow, buf_we;
  logic [7:0]  buf_addr;
  logic [15:0] buf_data;

  exp_t exp_q[$];
  int   checks = 0, errors = 0, we_cnt = 0, base;
  logic [7:0] exp_addr = 8'd0;
  logic we_prev = 1'b0;

  i2s_rx_capture dut (
    .clk(clk), .rstn(rstn),
    .audio_I2S_bclk(bclk), .audio_I2S_reclrc(lrc), .audio_I2S_recdat(dat),
    .enable(enable),
    .sample_left(sample_left), .sample_right(sample_right),
    .valid(valid), .ready(ready),
    .overflow(overflow), .clear_overflow(clear_overflow),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] avg16(input logic [15:0] l, input logic [15:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return 16'(s >>> 1);
  endfunction

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r,
                          input logic [15:0] avg, input logic ovf);
    exp_t e;
    e.l = l; e.r = r; e.avg = avg; e.addr = exp_addr; e.ovf = ovf;
    exp_q.push_back(e);
    exp_addr = exp_addr + 8'd1;
  endtask

  // One bclk period (5 clk): data and word-select change on the falling edge.
  task automatic send_bit(input logic ws, input logic d);
    bclk = 1'b0; lrc = ws; dat = d;
    #25;
    bclk = 1'b1;
    #25;
  endtask

  // Slot 0 carries a junk bit on the word-select change, slots 1..nbits the word
  // MSB first, later slots padding ones.
  task automatic send_chan(input logic ws, input logic [15:0] word, input int nbits,
                           input int lo, input int hi);
    logic [15:0] sh;
    logic b;
    for (int i = lo; i <= hi; i++) begin
      if (i == 0 || i > nbits) b = 1'b1;
      else begin
        sh = word >> (nbits - i);
        b  = sh[0];
      end
      send_bit(ws, b);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int nbits, input int slot);
    send_chan(1'b0, l, nbits, 0, slot - 1);
    send_chan(1'b1, r, nbits, 0, slot - 1);
  endtask

  task automatic wait_sb(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d frames outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_left"},  16'(sample_left),  16'h0000);
    chk({name, "_right"}, 16'(sample_right), 16'h0000);
    chk({name, "_valid"}, 16'(valid),        16'h0000);
    chk({name, "_ovf"},   16'(overflow),     16'h0000);
    chk({name, "_addr"},  16'(buf_addr),     16'h0000);
    chk({name, "_data"},  buf_data,          16'h0000);
    chk({name, "_we"},    16'(buf_we),       16'h0000);
  endtask

  // Monitor: every buf_we cycle must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && buf_we) begin
        we_cnt++;
        chk("we_one_cycle", 16'(we_prev), 16'h0000);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got left=%h right=%h, required no frame",
                   sample_left, sample_right);
        end else begin
          e = exp_q.pop_front();
          chk("sample_left",  16'(sample_left),  e.l);
          chk("sample_right", 16'(sample_right), e.r);
          chk("buf_data",     buf_data,          e.avg);
          chk("buf_addr",     16'(buf_addr),     16'(e.addr));
          chk("valid_at_we",  16'(valid),        16'h0001);
          chk("ovf_at_we",    16'(overflow),     16'(e.ovf));
        end
      end
      we_prev = buf_we;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with ready held high.
    enable = 1'b1;
    send_chan(1'b1, 16'h0000, 0, 0, 3);
    push_exp(16'h8001, 16'h7FFE, 16'hFFFF, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 16, 20);
    wait_sb("basic");
    chk("basic_valid_dropped", 16'(valid), 16'h0000);
    chk("basic_addr_after", 16'(buf_addr), 16'h0001);

    // Disable holds outputs; re-enable mid-right waits for the next left.
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("disable_left_held", 16'(sample_left), 16'h8001);
    chk("disable_addr_held", 16'(buf_addr), 16'h0001);
    send_chan(1'b0, 16'h5555, 16, 0, 19);
    send_chan(1'b1, 16'hAAAA, 16, 0, 9);
    enable = 1'b1;
    send_chan(1'b1, 16'hAAAA, 16, 10, 19);
    chk("midright_no_valid", 16'(valid), 16'h0000);
    push_exp(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
    send_frame(16'h7FFF, 16'h7FFF, 16, 20);
    wait_sb("midright");

    // Back-pressure: second frame overwrites and sets overflow.
    ready = 1'b0;
    push_exp(16'h1111, 16'h2222, 16'h1999, 1'b0);
    push_exp(16'h1234, 16'h5678, 16'h3456, 1'b1);
    send_frame(16'h1111, 16'h2222, 16, 20);
    send_frame(16'h1234, 16'h5678, 16, 20);
    wait_sb("backpressure");
    chk("bp_valid_held", 16'(valid), 16'h0001);
    chk("bp_left", 16'(sample_left), 16'h1234);
    chk("bp_overflow", 16'(overflow), 16'h0001);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    @(negedge clk);
    chk("bp_overflow_cleared", 16'(overflow), 16'h0000);
    // Clear held high while another frame lands on an unconsumed one.
    clear_overflow = 1'b1;
    push_exp(16'h8000, 16'h8000, 16'h8000, 1'b1);
    send_frame(16'h8000, 16'h8000, 16, 20);
    wait_sb("set_vs_clear");
    clear_overflow = 1'b0;
    @(negedge clk);
    chk("clear_after_set", 16'(overflow), 16'h0000);
    chk("bp_valid_still", 16'(valid), 16'h0001);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp_valid_released", 16'(valid), 16'h0000);

    // Short 12-bit words are zero-filled at the LSB end.
    push_exp(16'hABC0, 16'h5A50, 16'h0308, 1'b0);
    push_exp(16'h0100, 16'h0300, 16'h0200, 1'b0);
    send_frame(16'h0ABC, 16'h05A5, 12, 13);
    send_frame(16'h0100, 16'h0300, 16, 20);
    wait_sb("short");

    // Reset during the 8th left bit abandons the frame.
    send_chan(1'b0, 16'h1357, 16, 0, 7);
    bclk = 1'b0; lrc = 1'b0; dat = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_zero("midreset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_addr = 8'd0;
    #15;
    bclk = 1'b1;
    #25;
    send_chan(1'b0, 16'h1357, 16, 9, 19);
    send_chan(1'b1, 16'h2468, 16, 0, 19);
    push_exp(16'h0F0F, 16'h0101, 16'h0808, 1'b0);
    send_frame(16'h0F0F, 16'h0101, 16, 20);
    wait_sb("after_reset");

    // Ring-buffer wrap over 257 frames.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_addr = 8'd0;
    base = we_cnt;
    send_chan(1'b1, 16'h0000, 0, 0, 3);
    for (int i = 0; i < 257; i++) begin
      logic [15:0] l, r;
      l = 16'(i * 977);
      r = 16'(16'hFFFF - 16'(i * 1231));
      push_exp(l, r, avg16(l, r), 1'b0);
      send_frame(l, r, 16, 17);
    end
    wait_sb("wrap");
    chk("wrap_we_count", 16'(we_cnt - base), 16'd257);
    chk("wrap_addr_after", 16'(buf_addr), 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
